// File: rtl/text_term_writer.sv
// ----------------------------------------------------------------------------
// text_term_writer
//
// Terminal front end for the text-mode display. Consumes a byte stream,
// interprets printable characters and a small set of control codes, tracks
// the cursor and turns each byte into zero or more display commands
// (single-cell write, full clear, scroll copy + blank last row). Exactly one
// command is in flight at a time; the next one is only started after the
// display has pulsed wr_complete for the previous one.
//
// Ports
//   clk100       in   system clock, rising edge
//   rst          in   synchronous reset, active-high
//   rx_valid     in   rx_data carries a byte
//   rx_data      in   incoming byte
//   rx_ready     out  byte taken on a cycle with rx_valid && rx_ready
//   wr_start     out  one-cycle command strobe
//   wr_begin     out  first cell address (row*COLS+col)
//   wr_end       out  exclusive end address
//   wr_data      out  fill value (used when wr_offset == 0)
//   wr_offset    out  0: fill, nonzero: cell[a] <= cell[a+wr_offset]
//   wr_complete  in   display finished the current command
//   cursor_col   out  current column
//   cursor_row   out  current row
//   busy         out  command sequence in progress (!rx_ready)
// ----------------------------------------------------------------------------
module text_term_writer #(
  parameter int unsigned COLS           = 80,
  parameter int unsigned ROWS           = 25,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk100,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        wr_start,
  output logic [10:0] wr_begin,
  output logic [10:0] wr_end,
  output logic [7:0]  wr_data,
  output logic [7:0]  wr_offset,
  input  logic        wr_complete,
  output logic [6:0]  cursor_col,
  output logic [4:0]  cursor_row,
  output logic        busy
);

  typedef struct packed {
    logic [10:0] b;
    logic [10:0] e;
    logic [7:0]  d;
    logic [7:0]  o;
  } cmd_t;

  // S_INIT only exists to load the post-reset clear so that wr_* are valid
  // in the same cycle that wr_start is high.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_INIT  = 2'd3
  } state_t;

  // Commands still owed after the one currently in flight.
  typedef enum logic [1:0] {
    Q_NONE    = 2'd0,
    Q_SCROLL1 = 2'd1,
    Q_SCROLL2 = 2'd2
  } queue_t;

  localparam logic [10:0] COLS_A      = 11'(COLS);
  localparam logic [10:0] LAST_BASE   = 11'((ROWS - 1) * COLS);
  localparam logic [10:0] SCREEN_END  = 11'(ROWS * COLS);
  localparam logic [6:0]  COL_LAST    = 7'(COLS - 1);
  localparam logic [4:0]  ROW_LAST    = 5'(ROWS - 1);
  localparam logic [7:0]  SCROLL_OFS  = 8'(COLS);

  localparam cmd_t CLEAR_CMD   = '{b: 11'd0,     e: SCREEN_END, d: 8'h00, o: 8'h00};
  localparam cmd_t SCROLL1_CMD = '{b: 11'd0,     e: LAST_BASE,  d: 8'h00, o: SCROLL_OFS};
  localparam cmd_t SCROLL2_CMD = '{b: LAST_BASE, e: SCREEN_END, d: 8'h00, o: 8'h00};

  localparam state_t RESET_STATE = CLEAR_ON_RESET ? S_INIT : S_IDLE;
  localparam logic   RESET_READY = CLEAR_ON_RESET ? 1'b0 : 1'b1;

  state_t      state_q,    state_d;
  queue_t      queue_q,    queue_d;
  cmd_t        cmd_q,      cmd_d;
  logic        wr_start_q, wr_start_d;
  logic        rx_ready_q, rx_ready_d;
  logic [6:0]  col_q,      col_d;
  logic [4:0]  row_q,      row_d;
  logic [10:0] cell_addr;
  logic        printable;

  assign cell_addr = 11'(row_q) * COLS_A + 11'(col_q);
  assign printable = (rx_data >= 8'h20) && (rx_data <= 8'h7E);

  // Next-state, command loading and cursor update.
  always_comb begin
    state_d = state_q;
    queue_d = queue_q;
    cmd_d   = cmd_q;
    col_d   = col_q;
    row_d   = row_q;

    case (state_q)
      S_INIT: begin
        cmd_d   = CLEAR_CMD;
        queue_d = Q_NONE;
        state_d = S_START;
      end

      S_IDLE: begin
        if (rx_valid) begin
          if (printable) begin
            cmd_d   = '{b: cell_addr, e: cell_addr + 11'd1, d: rx_data + 8'd1, o: 8'h00};
            state_d = S_START;
            if (col_q == COL_LAST) begin
              // Wrap: the write goes out first, a scroll may follow it.
              col_d = 7'd0;
              if (row_q != ROW_LAST) begin
                row_d   = row_q + 5'd1;
                queue_d = Q_NONE;
              end else begin
                queue_d = Q_SCROLL1;
              end
            end else begin
              col_d   = col_q + 7'd1;
              queue_d = Q_NONE;
            end
          end else begin
            case (rx_data)
              8'h0A: begin
                if (row_q != ROW_LAST) begin
                  row_d = row_q + 5'd1;
                end else begin
                  cmd_d   = SCROLL1_CMD;
                  queue_d = Q_SCROLL2;
                  state_d = S_START;
                end
              end
              8'h0D: begin
                col_d = 7'd0;
              end
              8'h08: begin
                if (col_q != 7'd0) begin
                  col_d = col_q - 7'd1;
                end else begin
                  col_d = col_q;
                end
              end
              8'h0C: begin
                cmd_d   = CLEAR_CMD;
                queue_d = Q_NONE;
                col_d   = 7'd0;
                row_d   = 5'd0;
                state_d = S_START;
              end
              default: begin
                state_d = S_IDLE;
              end
            endcase
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_START: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (wr_complete) begin
          case (queue_q)
            Q_SCROLL1: begin
              cmd_d   = SCROLL1_CMD;
              queue_d = Q_SCROLL2;
              state_d = S_START;
            end
            Q_SCROLL2: begin
              cmd_d   = SCROLL2_CMD;
              queue_d = Q_NONE;
              state_d = S_START;
            end
            default: begin
              queue_d = Q_NONE;
              state_d = S_IDLE;
            end
          endcase
        end else begin
          state_d = S_WAIT;
        end
      end

      default: begin
        queue_d = Q_NONE;
        state_d = S_IDLE;
      end
    endcase

    // Strobe and ready are registered from the state being entered.
    wr_start_d = (state_d == S_START);
    rx_ready_d = (state_d == S_IDLE);
  end

  // State, command and cursor registers with synchronous reset.
  always_ff @(posedge clk100) begin
    if (rst) begin
      state_q    <= RESET_STATE;
      queue_q    <= Q_NONE;
      cmd_q      <= '{b: 11'd0, e: 11'd0, d: 8'h00, o: 8'h00};
      wr_start_q <= 1'b0;
      rx_ready_q <= RESET_READY;
      col_q      <= 7'd0;
      row_q      <= 5'd0;
    end else begin
      state_q    <= state_d;
      queue_q    <= queue_d;
      cmd_q      <= cmd_d;
      wr_start_q <= wr_start_d;
      rx_ready_q <= rx_ready_d;
      col_q      <= col_d;
      row_q      <= row_d;
    end
  end

  assign rx_ready   = rx_ready_q;
  assign busy       = ~rx_ready_q;
  assign wr_start   = wr_start_q;
  assign wr_begin   = cmd_q.b;
  assign wr_end     = cmd_q.e;
  assign wr_data    = cmd_q.d;
  assign wr_offset  = cmd_q.o;
  assign cursor_col = col_q;
  assign cursor_row = row_q;

endmodule

// File: tb/tb_text_term_writer.sv
// ----------------------------------------------------------------------------
// tb_text_term_writer
//
// Bench for text_term_writer (80x25, clear on reset). A display responder
// answers each wr_start with a wr_complete pulse; a monitor records every
// strobed command. A reference model applies the terminal rules to the byte
// stream and produces the expected command list and cursor.
// ----------------------------------------------------------------------------
module tb_text_term_writer;

  localparam int COLS = 80;
  localparam int ROWS = 25;

  logic        clk100 = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        wr_start;
  logic [10:0] wr_begin;
  logic [10:0] wr_end;
  logic [7:0]  wr_data;
  logic [7:0]  wr_offset;
  logic        wr_complete;
  logic [6:0]  cursor_col;
  logic [4:0]  cursor_row;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  typedef logic [37:0] cmd_t;
  cmd_t got_q[$];
  cmd_t exp_q[$];

  int mc;
  int mr;

  int resp_delay = 5;
  bit resp_rand  = 1'b0;
  bit resp_en    = 1'b1;
  bit inject     = 1'b0;
  int cnt        = 0;
  logic prev_start = 1'b0;

  text_term_writer #(.COLS(80), .ROWS(25), .CLEAR_ON_RESET(1'b1)) dut (
    .clk100      (clk100),
    .rst         (rst),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .wr_start    (wr_start),
    .wr_begin    (wr_begin),
    .wr_end      (wr_end),
    .wr_data     (wr_data),
    .wr_offset   (wr_offset),
    .wr_complete (wr_complete),
    .cursor_col  (cursor_col),
    .cursor_row  (cursor_row),
    .busy        (busy)
  );

  always #5 clk100 = ~clk100;

  function automatic cmd_t mk(input int b, input int e, input int d, input int o);
    return {11'(b), 11'(e), 8'(d), 8'(o)};
  endfunction

  // Reference model: terminal rules applied to one accepted byte.
  task automatic line_adv();
    if (mr < ROWS - 1) mr = mr + 1;
    else begin
      exp_q.push_back(mk(0, (ROWS - 1) * COLS, 0, COLS));
      exp_q.push_back(mk((ROWS - 1) * COLS, ROWS * COLS, 0, 0));
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      exp_q.push_back(mk(mr * COLS + mc, mr * COLS + mc + 1, (int'(b) + 1) % 256, 0));
      if (mc == COLS - 1) begin
        mc = 0;
        line_adv();
      end else mc = mc + 1;
    end else if (b == 8'h0A) line_adv();
    else if (b == 8'h0D) mc = 0;
    else if (b == 8'h08) begin
      if (mc > 0) mc = mc - 1;
    end else if (b == 8'h0C) begin
      exp_q.push_back(mk(0, ROWS * COLS, 0, 0));
      mc = 0;
      mr = 0;
    end
  endtask

  // Monitor of strobed commands plus display responder.
  always @(negedge clk100) begin
    if (wr_start === 1'b1) begin
      got_q.push_back({wr_begin, wr_end, wr_data, wr_offset});
      checks++;
      if (prev_start === 1'b1) begin
        failures++;
        $display("FAIL strobe_width: wr_start high for 2+ cycles, required 1");
      end
    end
    prev_start = wr_start;
    wr_complete = 1'b0;
    if (rst === 1'b1) cnt = 0;
    else if (inject) begin
      wr_complete = 1'b1;
      inject = 1'b0;
    end else if (cnt > 0) begin
      cnt = cnt - 1;
      if (cnt == 0) wr_complete = 1'b1;
    end else if (wr_start === 1'b1 && resp_en)
      cnt = resp_rand ? int'($urandom_range(1, 6)) : resp_delay;
  end

  // Called on a negedge; returns on the negedge after acceptance.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (rx_ready !== 1'b1 && n < 2000) begin
      @(negedge clk100);
      n++;
    end
    if (rx_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: byte %h not accepted, rx_ready=%b required 1", b, rx_ready);
    end else begin
      @(posedge clk100);
      model_byte(b);
    end
    @(negedge clk100);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge clk100);
      n++;
    end while (rx_ready !== 1'b1 && n < 2000);
    if (rx_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL %s_idle_timeout: rx_ready=%b required 1", name, rx_ready);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(negedge clk100);
    checks++;
    if ({wr_start, wr_begin, wr_end, wr_data, wr_offset, rx_ready, busy, cursor_col, cursor_row}
        !== {1'b0, 11'd0, 11'd0, 8'd0, 8'd0, 1'b0, 1'b1, 7'd0, 5'd0}) begin
      failures++;
      $display("FAIL reset_values: start=%b b=%0d e=%0d d=%h o=%h rdy=%b busy=%b cur=(%0d,%0d) required 0,0,0,00,00,0,1,(0,0)",
               wr_start, wr_begin, wr_end, wr_data, wr_offset, rx_ready, busy, cursor_col, cursor_row);
    end
    got_q.delete();
    rst = 1'b0;
    mc = 0;
    mr = 0;
    wait_idle("reset");
    checks++;
    if (got_q.size() != 1) begin
      failures++;
      $display("FAIL reset_clear_count: got %0d strobes, required 1", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== mk(0, 2000, 0, 0)) begin
        failures++;
        $display("FAIL reset_clear_cmd: got %h, required %h", got_q[0], mk(0, 2000, 0, 0));
      end
    end
    checks++;
    if ({busy, cursor_col, cursor_row} !== {1'b0, 7'd0, 5'd0}) begin
      failures++;
      $display("FAIL reset_after_clear: busy=%b cur=(%0d,%0d) required 0,(0,0)", busy, cursor_col, cursor_row);
    end
  endtask

  task automatic test_print_cr();
    got_q.delete();
    exp_q.delete();
    send_byte(8'h41);
    rx_valid = 1'b0;
    wait_idle("print");
    checks++;
    if (got_q.size() != 1 || got_q[0] !== mk(0, 1, 8'h42, 0)) begin
      failures++;
      $display("FAIL print_A: got %0d strobes first=%h, required 1 strobe %h", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : cmd_t'(0), mk(0, 1, 8'h42, 0));
    end
    checks++;
    if ({cursor_col, cursor_row} !== {7'd1, 5'd0}) begin
      failures++;
      $display("FAIL print_cursor: got (%0d,%0d), required (1,0)", cursor_col, cursor_row);
    end
    send_byte(8'h0D);
    rx_valid = 1'b0;
    wait_idle("cr");
    checks++;
    if (got_q.size() != 1 || {cursor_col, cursor_row} !== {7'd0, 5'd0}) begin
      failures++;
      $display("FAIL cr: got %0d strobes cur=(%0d,%0d), required 1 strobe (0,0)", got_q.size(), cursor_col, cursor_row);
    end
  endtask

  task automatic test_controls();
    got_q.delete();
    exp_q.delete();
    repeat (3) send_byte(8'h0A);
    send_byte(8'h0A);
    send_byte(8'h08);
    send_byte(8'h07);
    rx_valid = 1'b0;
    wait_idle("ctrl");
    checks++;
    if (got_q.size() != 0 || {cursor_col, cursor_row} !== {7'd0, 5'd4}) begin
      failures++;
      $display("FAIL ctrl_no_cmd: got %0d strobes cur=(%0d,%0d), required 0 strobes (0,4)", got_q.size(), cursor_col, cursor_row);
    end
    send_byte(8'h78);
    send_byte(8'h79);
    send_byte(8'h08);
    rx_valid = 1'b0;
    wait_idle("bs");
    checks++;
    if (got_q.size() != 2 || got_q[1] !== mk(4 * 80 + 1, 4 * 80 + 2, 8'h7A, 0)) begin
      failures++;
      $display("FAIL bs_writes: got %0d strobes, required 2 ending %h", got_q.size(), mk(321, 322, 8'h7A, 0));
    end
    checks++;
    if ({cursor_col, cursor_row} !== {7'd1, 5'd4}) begin
      failures++;
      $display("FAIL bs_cursor: got (%0d,%0d), required (1,4)", cursor_col, cursor_row);
    end
  endtask

  task automatic test_formfeed();
    send_byte(8'h0D);
    while (mr < 9) send_byte(8'h0A);
    repeat (17) send_byte(8'h2E);
    rx_valid = 1'b0;
    wait_idle("ff_setup");
    checks++;
    if ({cursor_col, cursor_row} !== {7'd17, 5'd9}) begin
      failures++;
      $display("FAIL ff_setup_cursor: got (%0d,%0d), required (17,9)", cursor_col, cursor_row);
    end
    got_q.delete();
    exp_q.delete();
    send_byte(8'h0C);
    rx_valid = 1'b0;
    wait_idle("ff");
    checks++;
    if (got_q.size() != 1 || got_q[0] !== mk(0, 2000, 0, 0)) begin
      failures++;
      $display("FAIL ff_cmd: got %0d strobes first=%h, required 1 strobe %h", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : cmd_t'(0), mk(0, 2000, 0, 0));
    end
    checks++;
    if ({cursor_col, cursor_row} !== {7'd0, 5'd0}) begin
      failures++;
      $display("FAIL ff_cursor: got (%0d,%0d), required (0,0)", cursor_col, cursor_row);
    end
  endtask

  task automatic test_wrap_scroll();
    send_byte(8'h0C);
    repeat (24) send_byte(8'h0A);
    rx_valid = 1'b0;
    wait_idle("wrap_setup");
    got_q.delete();
    exp_q.delete();
    repeat (80) send_byte(8'h42);
    rx_valid = 1'b0;
    wait_idle("wrap");
    checks++;
    if (got_q.size() != 82) begin
      failures++;
      $display("FAIL wrap_count: got %0d strobes, required 82", got_q.size());
    end else begin
      checks++;
      if (got_q[79] !== mk(1999, 2000, 8'h43, 0) || got_q[80] !== mk(0, 1920, 0, 80) ||
          got_q[81] !== mk(1920, 2000, 0, 0)) begin
        failures++;
        $display("FAIL wrap_tail: got %h %h %h, required %h %h %h", got_q[79], got_q[80], got_q[81],
                 mk(1999, 2000, 8'h43, 0), mk(0, 1920, 0, 80), mk(1920, 2000, 0, 0));
      end
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL wrap_model[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if ({cursor_col, cursor_row} !== {7'd0, 5'd24}) begin
      failures++;
      $display("FAIL wrap_cursor: got (%0d,%0d), required (0,24)", cursor_col, cursor_row);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    int sel;
    got_q.delete();
    exp_q.delete();
    resp_rand = 1'b1;
    for (int i = 0; i < 250; i++) begin
      sel = int'($urandom_range(0, 19));
      case (sel)
        0, 1, 2: b = 8'h0A;
        3:       b = 8'h0D;
        4:       b = 8'h08;
        5:       b = ($urandom_range(0, 7) == 0) ? 8'h0C : 8'h09;
        6:       b = 8'($urandom_range(0, 255));
        default: b = 8'($urandom_range(32, 126));
      endcase
      send_byte(b);
    end
    rx_valid = 1'b0;
    wait_idle("random");
    resp_rand = 1'b0;
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL random_count: got %0d strobes, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL random_cmd[%0d]: got %h, required %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if ({cursor_col, cursor_row} !== {7'(mc), 5'(mr)}) begin
      failures++;
      $display("FAIL random_cursor: got (%0d,%0d), required (%0d,%0d)", cursor_col, cursor_row, mc, mr);
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    send_byte(8'h0C);
    repeat (24) send_byte(8'h0A);
    rx_valid = 1'b0;
    wait_idle("mid_setup");
    resp_en = 1'b0;
    got_q.delete();
    send_byte(8'h0A);
    rx_valid = 1'b0;
    while (got_q.size() == 0 && n < 50) begin
      @(negedge clk100);
      n++;
    end
    checks++;
    if (got_q.size() != 1 || got_q[0] !== mk(0, 1920, 0, 80)) begin
      failures++;
      $display("FAIL mid_step1: got %0d strobes, required 1 strobe %h", got_q.size(), mk(0, 1920, 0, 80));
    end
    repeat (3) @(negedge clk100);
    rst = 1'b1;
    repeat (2) @(negedge clk100);
    checks++;
    if ({wr_start, wr_begin, wr_end, wr_data, wr_offset, rx_ready, cursor_col, cursor_row}
        !== {1'b0, 11'd0, 11'd0, 8'd0, 8'd0, 1'b0, 7'd0, 5'd0}) begin
      failures++;
      $display("FAIL mid_reset_values: start=%b b=%0d e=%0d o=%h rdy=%b cur=(%0d,%0d) required all zero",
               wr_start, wr_begin, wr_end, wr_offset, rx_ready, cursor_col, cursor_row);
    end
    rst = 1'b0;
    got_q.delete();
    @(posedge clk100);
    #1 inject = 1'b1;
    @(negedge clk100);
    checks++;
    if (wr_start !== 1'b1 || {wr_begin, wr_end, wr_data, wr_offset} !== mk(0, 2000, 0, 0)) begin
      failures++;
      $display("FAIL mid_clear_start: start=%b cmd=%h, required 1 %h", wr_start,
               {wr_begin, wr_end, wr_data, wr_offset}, mk(0, 2000, 0, 0));
    end
    repeat (3) @(negedge clk100);
    checks++;
    if (rx_ready !== 1'b0 || got_q.size() != 1) begin
      failures++;
      $display("FAIL mid_stray_complete: rx_ready=%b strobes=%0d, required 0 and 1", rx_ready, got_q.size());
    end
    @(posedge clk100);
    #1 inject = 1'b1;
    wait_idle("mid");
    checks++;
    if (got_q.size() != 1 || {cursor_col, cursor_row, busy} !== {7'd0, 5'd0, 1'b0}) begin
      failures++;
      $display("FAIL mid_final: strobes=%0d cur=(%0d,%0d) busy=%b, required 1 (0,0) 0", got_q.size(), cursor_col, cursor_row, busy);
    end
    resp_en = 1'b1;
    mc = 0;
    mr = 0;
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    @(negedge clk100);
    test_reset();
    test_print_cr();
    test_controls();
    test_formfeed();
    test_wrap_scroll();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
